reg_file: RTL and testbench

Architectural register file for the ARM32 core. It holds r0–r14 and services the three read and two write requests produced by the register-access decode in the same cycle, with write-first bypass. It also holds a load-pending scoreboard so that multi-cycle load returns can write back through a ready/valid handshake. Read-after-load hazards are flagged to the pipeline control as a stall.

---
 rtl/reg_file.sv | 129 ++++++++++++
 tb/tb_reg_file.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: ARM32 architectural register file (r0-r14 stored, r15 = pc + 8).
// Three combinational read ports with write-first bypass, two write ports,
// and a load-pending scoreboard whose returns write back over a valid/ready
// handshake that shares the second physical write path.
//
// Handshake: a load return transfers in any cycle where ld_valid & ld_ready;
// while ld_valid=1 and ld_ready=0 the source holds ld_reg/ld_data stable.
// ld_ready drops whenever write port 2 is in use or reset is asserted.
module reg_file (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [3:0]  rf_rs1,
    input  logic [3:0]  rf_rs2,
    input  logic [3:0]  rf_rs3,
    output logic [31:0] rf_rd1,
    output logic [31:0] rf_rd2,
    output logic [31:0] rf_rd3,
    input  logic [31:0] pc,
    input  logic [3:0]  rf_ws1,
    input  logic [3:0]  rf_ws2,
    input  logic [31:0] rf_wd1,
    input  logic [31:0] rf_wd2,
    input  logic        rf_we1,
    input  logic        rf_we2,
    input  logic        ld_issue,
    input  logic [3:0]  ld_tag,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic [15:0] busy,
    output logic        rf_stall,
    output logic        pc_wr
);

    localparam logic [3:0] PC_IDX = 4'd15;

    logic [31:0] regs [0:14];
    logic [15:0] busy_q;

    // Write qualifiers: nothing writes while reset is held.
    logic we1_eff;
    logic we2_eff;
    logic ld_acc;

    assign ld_ready = rst_b & ~rf_we2;
    assign ld_acc   = ld_valid & ld_ready;
    assign we1_eff  = rf_we1 & rst_b;
    assign we2_eff  = rf_we2 & rst_b;

    // r15 writes are reported to the fetch logic and never stored here.
    assign pc_wr = (rf_we1 & (rf_ws1 == PC_IDX)) | (rf_we2 & (rf_ws2 == PC_IDX));

    assign busy = busy_q;

    logic [3:0]  rs [0:2];
    logic [31:0] rd [0:2];

    assign rs[0]  = rf_rs1;
    assign rs[1]  = rf_rs2;
    assign rs[2]  = rf_rs3;
    assign rf_rd1 = rd[0];
    assign rf_rd2 = rd[1];
    assign rf_rd3 = rd[2];

    // Read ports with write-first bypass (lowest priority applied first so the
    // winning write overrides) and read-after-load stall detection.
    always_comb begin
        rf_stall = 1'b0;
        for (int p = 0; p < 3; p++) begin
            rd[p] = 32'h0;
            for (int i = 0; i < 15; i++) begin
                if (rs[p] == 4'(i)) begin
                    rd[p] = regs[i];
                end
            end
            if (rs[p] == PC_IDX) begin
                rd[p] = pc + 32'd8;
            end else begin
                if (ld_acc && (ld_reg == rs[p])) begin
                    rd[p] = ld_data;
                end
                if (we2_eff && (rf_ws2 == rs[p])) begin
                    rd[p] = rf_wd2;
                end
                if (we1_eff && (rf_ws1 == rs[p])) begin
                    rd[p] = rf_wd1;
                end
            end
            // A same-cycle accepted return to the register supplies the data.
            if (rst_b && busy_q[rs[p]] && !(ld_acc && (ld_reg == rs[p]))) begin
                rf_stall = 1'b1;
            end
        end
    end

    // Register array: port 1 beats port 2 beats the load return.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (!rst_b) begin
                regs[i] <= 32'h0;
            end else if (we1_eff && (rf_ws1 == 4'(i))) begin
                regs[i] <= rf_wd1;
            end else if (we2_eff && (rf_ws2 == 4'(i))) begin
                regs[i] <= rf_wd2;
            end else if (ld_acc && (ld_reg == 4'(i))) begin
                regs[i] <= ld_data;
            end
        end
    end

    // Scoreboard: an issue in the same cycle as a return to the same
    // register wins; r15 can never be marked busy.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            busy_q <= 16'h0000;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (ld_issue && (ld_tag == 4'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (ld_acc && (ld_reg == 4'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
            busy_q[15] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, bypass, write collisions, r15 handling,
// load scoreboard hazards, backpressure and reset while a load is pending.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  rf_rs1, rf_rs2, rf_rs3;
    logic [31:0] rf_rd1, rf_rd2, rf_rd3;
    logic [31:0] pc;
    logic [3:0]  rf_ws1, rf_ws2;
    logic [31:0] rf_wd1, rf_wd2;
    logic        rf_we1, rf_we2;
    logic        ld_issue;
    logic [3:0]  ld_tag;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_reg;
    logic [31:0] ld_data;
    logic [15:0] busy;
    logic        rf_stall;
    logic        pc_wr;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .rf_rs1   (rf_rs1),
        .rf_rs2   (rf_rs2),
        .rf_rs3   (rf_rs3),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .rf_rd3   (rf_rd3),
        .pc       (pc),
        .rf_ws1   (rf_ws1),
        .rf_ws2   (rf_ws2),
        .rf_wd1   (rf_wd1),
        .rf_wd2   (rf_wd2),
        .rf_we1   (rf_we1),
        .rf_we2   (rf_we2),
        .ld_issue (ld_issue),
        .ld_tag   (ld_tag),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_reg   (ld_reg),
        .ld_data  (ld_data),
        .busy     (busy),
        .rf_stall (rf_stall),
        .pc_wr    (pc_wr)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 unit past it to drive new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_b = 1'b0;
        rf_rs1 = 4'd3; rf_rs2 = 4'd14; rf_rs3 = 4'd15;
        pc = 32'h100;
        rf_ws1 = 4'd0; rf_ws2 = 4'd0; rf_wd1 = 32'h0; rf_wd2 = 32'h0;
        rf_we1 = 1'b0; rf_we2 = 1'b0;
        ld_issue = 1'b0; ld_tag = 4'd0;
        ld_valid = 1'b0; ld_reg = 4'd0; ld_data = 32'h0;

        // Reset then read.
        tick();
        settle();
        check("rst_rd1", rf_rd1, 32'h0);
        check("rst_rd2", rf_rd2, 32'h0);
        check("rst_rd3_pc8", rf_rd3, 32'h108);
        check("rst_busy", {16'h0, busy}, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        check("rst_stall", {31'h0, rf_stall}, 32'h0);
        rf_we2 = 1'b1; rf_ws2 = 4'd15;
        settle();
        check("rst_pc_wr_ungated", {31'h0, pc_wr}, 32'h1);
        rf_we2 = 1'b0; rf_ws2 = 4'd0;
        rst_b = 1'b1;
        tick();

        // Write and bypass.
        rf_we1 = 1'b1; rf_ws1 = 4'd5; rf_wd1 = 32'hDEADBEEF;
        rf_rs1 = 4'd5; rf_rs2 = 4'd6;
        settle();
        check("bypass_rd1", rf_rd1, 32'hDEADBEEF);
        check("no_bypass_rd2", rf_rd2, 32'h0);
        tick();
        rf_we1 = 1'b0;
        settle();
        check("stored_r5", rf_rd1, 32'hDEADBEEF);

        // Collision between port 1 and port 2.
        rf_we1 = 1'b1; rf_ws1 = 4'd7; rf_wd1 = 32'h11;
        rf_we2 = 1'b1; rf_ws2 = 4'd7; rf_wd2 = 32'h22;
        rf_rs1 = 4'd7;
        settle();
        check("collide_bypass", rf_rd1, 32'h11);
        tick();
        rf_we1 = 1'b0; rf_we2 = 1'b0;
        settle();
        check("collide_stored", rf_rd1, 32'h11);

        // Port 2 write to r15: flagged, not stored, not bypassed.
        rf_we2 = 1'b1; rf_ws2 = 4'd15; rf_wd2 = 32'h55;
        rf_rs1 = 4'd15; rf_rs2 = 4'd7;
        settle();
        check("pc_wr_set", {31'h0, pc_wr}, 32'h1);
        check("r15_no_bypass", rf_rd1, 32'h108);
        tick();
        rf_we2 = 1'b0;
        settle();
        check("pc_wr_clear", {31'h0, pc_wr}, 32'h0);
        check("r7_untouched", rf_rd2, 32'h11);
        pc = 32'hFFFF_FFFC;
        settle();
        check("pc8_wrap", rf_rd1, 32'h4);
        pc = 32'h100;

        // Load hazard and return.
        ld_issue = 1'b1; ld_tag = 4'd4;
        tick();
        ld_issue = 1'b0;
        rf_rs2 = 4'd4;
        settle();
        check("ld_busy4", {16'h0, busy}, 32'h0010);
        check("ld_stall", {31'h0, rf_stall}, 32'h1);
        ld_valid = 1'b1; ld_reg = 4'd4; ld_data = 32'hCAFE;
        settle();
        check("ld_ready_up", {31'h0, ld_ready}, 32'h1);
        check("ld_ret_nostall", {31'h0, rf_stall}, 32'h0);
        check("ld_ret_bypass", rf_rd2, 32'hCAFE);
        tick();
        ld_valid = 1'b0;
        settle();
        check("ld_busy_cleared", {16'h0, busy}, 32'h0);
        check("ld_r4_stored", rf_rd2, 32'hCAFE);

        // Backpressure: port 2 in use holds off the load return.
        ld_valid = 1'b1; ld_reg = 4'd10; ld_data = 32'h1234;
        rf_we2 = 1'b1; rf_ws2 = 4'd11; rf_wd2 = 32'h77;
        rf_rs1 = 4'd10; rf_rs3 = 4'd11;
        settle();
        check("bp_not_ready", {31'h0, ld_ready}, 32'h0);
        check("bp_no_ld_bypass", rf_rd1, 32'h0);
        tick();
        rf_we2 = 1'b0;
        settle();
        check("bp_r10_unchanged_ready", {31'h0, ld_ready}, 32'h1);
        check("bp_ld_bypass", rf_rd1, 32'h1234);
        check("bp_r11_stored", rf_rd3, 32'h77);
        tick();
        ld_valid = 1'b0;
        settle();
        check("bp_r10_stored", rf_rd1, 32'h1234);

        // Port 1 beats a same-cycle load return to the same register.
        rf_we1 = 1'b1; rf_ws1 = 4'd12; rf_wd1 = 32'hAA;
        ld_valid = 1'b1; ld_reg = 4'd12; ld_data = 32'hBB;
        rf_rs1 = 4'd12;
        settle();
        check("prio_bypass", rf_rd1, 32'hAA);
        tick();
        rf_we1 = 1'b0; ld_valid = 1'b0;
        settle();
        check("prio_stored", rf_rd1, 32'hAA);

        // Issue to r15 is ignored; double issue needs only one return.
        ld_issue = 1'b1; ld_tag = 4'd15;
        tick();
        ld_issue = 1'b0;
        settle();
        check("issue_r15_ignored", {16'h0, busy}, 32'h0);
        ld_issue = 1'b1; ld_tag = 4'd3;
        tick();
        tick();
        ld_issue = 1'b0;
        settle();
        check("double_issue_busy", {16'h0, busy}, 32'h0008);
        ld_valid = 1'b1; ld_reg = 4'd3; ld_data = 32'h33;
        tick();
        ld_valid = 1'b0;
        settle();
        check("double_issue_cleared", {16'h0, busy}, 32'h0);

        // Simultaneous issue and return to r9, then reset mid-load.
        ld_issue = 1'b1; ld_tag = 4'd9;
        tick();
        ld_valid = 1'b1; ld_reg = 4'd9; ld_data = 32'h99;
        rf_rs1 = 4'd9;
        settle();
        check("r9_ret_nostall", {31'h0, rf_stall}, 32'h0);
        check("r9_ret_bypass", rf_rd1, 32'h99);
        tick();
        ld_issue = 1'b0; ld_valid = 1'b0;
        settle();
        check("r9_issue_wins", {16'h0, busy}, 32'h0200);
        check("r9_stall", {31'h0, rf_stall}, 32'h1);
        check("r9_stored", rf_rd1, 32'h99);
        rst_b = 1'b0;
        settle();
        check("midrst_stall_gated", {31'h0, rf_stall}, 32'h0);
        check("midrst_ld_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        settle();
        check("midrst_busy", {16'h0, busy}, 32'h0);
        check("midrst_r9", rf_rd1, 32'h0);
        rst_b = 1'b1;
        ld_valid = 1'b1; ld_reg = 4'd9; ld_data = 32'h3;
        tick();
        ld_valid = 1'b0;
        settle();
        check("late_ret_busy", {16'h0, busy}, 32'h0);
        check("late_ret_r9", rf_rd1, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
